// File: rtl/piso_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_ctrl_pkg
// Purpose  : Shared definitions for the PISO transmit arbiter: FSM state
//            encoding and the bit-counter width helper.
// Contents : S_IDLE, S_SHIFT, S_GAP  - 2-bit state encodings
//            CNT_W(width)            - counter width able to hold 0..width
// Revision : 1.0 - initial release
// ============================================================================
package piso_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // The counter is loaded with WIDTH itself, so it needs clog2(WIDTH+1) bits.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_core
// Purpose  : Parallel-load, right-shifting register feeding a serial line
//            LSB first.
// Ports    : clk     in   rising-edge clock
//            clr_n_i in   synchronous clear, active-low (wins over load/shift)
//            load_i  in   capture data_i this edge (wins over shift)
//            shift_i in   shift right by one this edge
//            data_i  in   WIDTH-bit parallel word
//            lsb_o   out  current bit 0 of the register
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign lsb_o = shreg_q[0];

endmodule
`default_nettype wire

// File: rtl/piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_arbiter
// Purpose  : Round-robin arbiter sharing one PISO serialiser between two
//            parallel-word requesters. The winning word is captured on a
//            valid/ready handshake and shifted out LSB first as a WIDTH-bit
//            frame, followed by one gap cycle.
// Ports    : clk          in   rising-edge clock
//            rst          in   synchronous reset, active-low
//            req0_valid   in   requester 0 has a word
//            req0_data    in   requester 0 word
//            req0_ready   out  requester 0 word accepted this edge
//            req1_valid   in   requester 1 has a word
//            req1_data    in   requester 1 word
//            req1_ready   out  requester 1 word accepted this edge
//            sout         out  serial data bit (registered, 0 when idle)
//            sout_valid   out  sout carries a frame bit
//            frame_start  out  first bit of a frame
//            grant_id     out  requester owning the current/last frame
//            busy         out  FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_arbiter
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             grant_id,
  output logic             busy
);

  localparam int          CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          grant_id_q, grant_id_d;
  logic          last_grant_q, last_grant_d;

  logic             idle;
  logic             win0, win1;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] load_data;
  logic             core_lsb;

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win last time goes first.
  assign idle  = (state_q == S_IDLE);
  assign win0  = req0_valid && (!req1_valid || last_grant_q);
  assign win1  = req1_valid && (!req0_valid || !last_grant_q);

  // Ready is gated by rst so nothing is accepted on an edge that resets.
  assign req0_ready = rst && idle && win0;
  assign req1_ready = rst && idle && win1;

  assign load      = req0_ready || req1_ready;
  assign load_data = req1_ready ? req1_data : req0_data;
  assign shift     = (state_q == S_SHIFT);

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .clr_n_i (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (load_data),
    .lsb_o   (core_lsb)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    // Serial outputs return to 0 unless a frame bit is being emitted.
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          cnt_d        = CNT_LOAD;
          grant_id_d   = req1_ready;
          last_grant_d = req1_ready;
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sout_d        = core_lsb;
        sout_valid_d  = 1'b1;
        frame_start_d = (cnt_q == CNT_LOAD);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_arbiter
// Purpose  : Directed bench for piso_tx_arbiter: a WIDTH=4 instance covers
//            reset, single and contended requests, round-robin fairness and
//            mid-frame reset; a WIDTH=1 instance covers the single-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst;
  logic       r0v, r1v;
  logic [3:0] r0d, r1d;
  logic       r0r, r1r;
  logic       so, sv, fs, gid, bsy;

  // WIDTH=1 instance
  logic       rst_b;
  logic       r0v_b, r1v_b;
  logic [0:0] r0d_b, r1d_b;
  logic       r0r_b, r1r_b;
  logic       so_b, sv_b, fs_b, gid_b, bsy_b;

  int n_vec = 0;
  int n_err = 0;

  piso_tx_arbiter #(.WIDTH(4)) u_dut (
    .clk (clk), .rst (rst),
    .req0_valid (r0v), .req0_data (r0d), .req0_ready (r0r),
    .req1_valid (r1v), .req1_data (r1d), .req1_ready (r1r),
    .sout (so), .sout_valid (sv), .frame_start (fs),
    .grant_id (gid), .busy (bsy)
  );

  piso_tx_arbiter #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst_b),
    .req0_valid (r0v_b), .req0_data (r0d_b), .req0_ready (r0r_b),
    .req1_valid (r1v_b), .req1_data (r1d_b), .req1_ready (r1r_b),
    .sout (so_b), .sout_valid (sv_b), .frame_start (fs_b),
    .grant_id (gid_b), .busy (bsy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake for requester g on the next edge, then the 4 frame bits of d
  // LSB first, then the gap cycle back to idle.
  task automatic frame4(input logic g, input logic [3:0] d, input string tag);
    chk({tag, "_rdy_win"}, g ? r1r : r0r, 8'd1);
    chk({tag, "_rdy_lose"}, g ? r0r : r1r, 8'd0);
    tick();
    chk({tag, "_gid"}, gid, g);
    chk({tag, "_sv_load"}, sv, 8'd0);
    chk({tag, "_busy"}, bsy, 8'd1);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk({tag, "_sout"}, so, d[b]);
      chk({tag, "_sv"}, sv, 8'd1);
      chk({tag, "_fs"}, fs, (b == 0) ? 8'd1 : 8'd0);
      chk({tag, "_rdy_busy"}, {r1r, r0r}, 8'd0);
    end
    tick();
    chk({tag, "_sv_gap"}, sv, 8'd0);
    chk({tag, "_sout_gap"}, so, 8'd0);
    chk({tag, "_idle"}, bsy, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] stream;

    // ---- 1: reset held for two edges with both requesters valid ----
    rst = 1'b0; r0v = 1'b1; r1v = 1'b1; r0d = 4'b1010; r1d = 4'b0111;
    rst_b = 1'b0; r0v_b = 1'b0; r1v_b = 1'b0; r0d_b = 1'b0; r1d_b = 1'b0;
    #1;
    chk("t1_rdy_pre", {r1r, r0r}, 8'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_outs", {bsy, gid, fs, sv, so}, 8'd0);
      chk("t1_rdy", {r1r, r0r}, 8'd0);
    end
    chk("t1_w1_outs", {bsy_b, gid_b, fs_b, sv_b, so_b}, 8'd0);
    rst_b = 1'b1;

    // ---- 3: contention from reset, req0 first then req1 ----
    rst = 1'b1;
    #1;
    frame4(1'b0, 4'b1010, "t3_a");
    frame4(1'b1, 4'b0111, "t3_b");
    r0v = 1'b0; r1v = 1'b0;

    // ---- 2: lone req0 word 1100 ----
    r0v = 1'b1; r0d = 4'b1100;
    #1;
    frame4(1'b0, 4'b1100, "t2");
    r0v = 1'b0;
    tick();
    chk("t2_sv_after", sv, 8'd0);
    chk("t2_busy_after", bsy, 8'd0);

    // ---- 4: both held valid for four frames ----
    rst = 1'b0;
    tick();
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1; r0d = 4'b0011; r1d = 4'b1001;
    #1;
    frame4(1'b0, 4'b0011, "t4_f0");
    frame4(1'b1, 4'b1001, "t4_f1");
    frame4(1'b0, 4'b0011, "t4_f2");
    frame4(1'b1, 4'b1001, "t4_f3");

    // ---- 5: reset during req1 frame, req1 stays valid ----
    r0v = 1'b0; r1d = 4'b0111;
    #1;
    chk("t5_rdy", r1r, 8'd1);
    tick();
    chk("t5_gid", gid, 8'd1);
    tick();
    chk("t5_bit0", {sv, so}, 8'b11);
    tick();
    chk("t5_bit1", {sv, so}, 8'b11);
    rst = 1'b0;
    #1;
    chk("t5_rdy_rst", r1r, 8'd0);
    tick();
    chk("t5_abort", {bsy, gid, fs, sv, so}, 8'd0);
    rst = 1'b1;
    #1;
    frame4(1'b1, 4'b0111, "t5_replay");
    r1v = 1'b0;

    // ---- 6: WIDTH=1, req0 stream 1,0,1 ----
    stream = 3'b101;
    r0v_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0d_b = stream[i];
      #1;
      chk("t6_rdy", r0r_b, 8'd1);
      tick();
      chk("t6_load", {gid_b, fs_b, sv_b}, 8'd0);
      tick();
      chk("t6_bit", {fs_b, sv_b, so_b}, {5'd0, 2'b11, stream[i]});
      tick();
      chk("t6_gap", {fs_b, sv_b, so_b}, 8'd0);
    end
    r0v_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
